// File: rtl/stage_pkg.sv
// Stage numbering and sequencer state encoding shared by the stage sequencer
// and anything that decodes or observes it.
package stage_pkg;

    localparam logic [2:0] STAGE_IDLE   = 3'd0;
    localparam logic [2:0] STAGE_FETCH  = 3'd1;
    localparam logic [2:0] STAGE_DECODE = 3'd2;
    localparam logic [2:0] STAGE_EXEC   = 3'd3;
    localparam logic [2:0] STAGE_MEM    = 3'd4;
    localparam logic [2:0] STAGE_WB     = 3'd5;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_ACTIVE = 2'd1,
        SEQ_HALTED = 2'd2,
        SEQ_FAULT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/stage_event_counter.sv
// Saturating event counter: increments on inc and sticks at all-ones.
module stage_event_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// Multicycle stage sequencer: run/halt/step control, wait-state stalls with
// timeout, and retirement/stall perf counters.
module stage_sequencer
    import stage_pkg::*;
#(
    parameter int WAIT_MAX = 4,
    parameter int CNT_W    = 16
) (
    input  logic             Clock,
    input  logic             Reset_L,
    input  logic             Run,
    input  logic             Step,
    input  logic             Halt_Req,
    input  logic             Mem_Access,
    input  logic             Mem_Ready,
    input  logic             Fetch_Ready,
    output logic [2:0]       Stage,
    output logic             Stage_Adv,
    output logic             Instr_Done,
    output logic             Halted,
    output logic             Timeout_Err,
    output logic [CNT_W-1:0] Instr_Count,
    output logic [CNT_W-1:0] Stall_Count,
    output seq_state_t       dbg_state
);

    localparam int                WAIT_W     = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);

    seq_state_t        state_q, state_d;
    logic [2:0]        stage_q, stage_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              prime_q, prime_d;
    logic              halt_pend_q, halt_pend_d;
    logic              step_mode_q, step_mode_d;
    logic              timeout_q, timeout_d;
    logic              instr_done_q;
    logic              run_q;
    logic              run_rise;
    logic              stall;
    logic              retire;

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q      <= SEQ_IDLE;
            stage_q      <= STAGE_IDLE;
            wait_q       <= '0;
            prime_q      <= 1'b0;
            halt_pend_q  <= 1'b0;
            step_mode_q  <= 1'b0;
            timeout_q    <= 1'b0;
            instr_done_q <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            wait_q       <= wait_d;
            prime_q      <= prime_d;
            halt_pend_q  <= halt_pend_d;
            step_mode_q  <= step_mode_d;
            timeout_q    <= timeout_d;
            instr_done_q <= retire;
            run_q        <= Run;
        end
    end

    // Mem_Ready / Fetch_Ready act as ready: the stage completes on a cycle where
    // ready is high; while low the stage holds and nothing is retired.
    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        wait_d      = wait_q;
        prime_d     = prime_q;
        halt_pend_d = halt_pend_q;
        step_mode_d = step_mode_q;
        timeout_d   = timeout_q;
        retire      = 1'b0;
        run_rise    = Run && !run_q;
        stall       = (state_q == SEQ_ACTIVE) &&
                      (((stage_q == STAGE_MEM) && Mem_Access && !Mem_Ready) ||
                       ((stage_q == STAGE_WB) && !Fetch_Ready));

        case (state_q)
            SEQ_IDLE: begin
                if (Run) begin
                    state_d = SEQ_ACTIVE;
                    stage_d = STAGE_WB;
                    prime_d = 1'b1;
                    wait_d  = '0;
                end
            end
            SEQ_ACTIVE: begin
                if (stall && (wait_q == WAIT_LIMIT)) begin
                    state_d   = SEQ_FAULT;
                    stage_d   = STAGE_IDLE;
                    timeout_d = 1'b1;
                end else if (stall) begin
                    wait_d = wait_q + WAIT_W'(1);
                end else begin
                    wait_d = '0;
                    case (stage_q)
                        STAGE_DECODE: begin
                            halt_pend_d = halt_pend_q || Halt_Req;
                            stage_d     = STAGE_EXEC;
                        end
                        STAGE_WB: begin
                            if (prime_q) begin
                                prime_d = 1'b0;
                                stage_d = STAGE_FETCH;
                            end else begin
                                retire = 1'b1;
                                if (halt_pend_q || !Run || step_mode_q) begin
                                    state_d     = SEQ_HALTED;
                                    stage_d     = STAGE_IDLE;
                                    halt_pend_d = 1'b0;
                                    step_mode_d = 1'b0;
                                end else begin
                                    stage_d = STAGE_FETCH;
                                end
                            end
                        end
                        default: stage_d = stage_q + 3'd1;
                    endcase
                end
            end
            SEQ_HALTED: begin
                // The IR already holds the next instruction, so no priming pass.
                if (run_rise || Step) begin
                    state_d     = SEQ_ACTIVE;
                    stage_d     = STAGE_FETCH;
                    wait_d      = '0;
                    step_mode_d = !run_rise;
                end
            end
            default: ;
        endcase
    end

    stage_event_counter #(.WIDTH(CNT_W)) u_instr_cnt (
        .clk   (Clock),
        .rst_n (Reset_L),
        .inc   (retire),
        .count (Instr_Count)
    );

    stage_event_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (Clock),
        .rst_n (Reset_L),
        .inc   (stall),
        .count (Stall_Count)
    );

    assign Stage       = stage_q;
    assign Stage_Adv   = (state_q == SEQ_ACTIVE) && !stall;
    assign Instr_Done  = instr_done_q;
    assign Halted      = (state_q == SEQ_HALTED);
    assign Timeout_Err = timeout_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed vector table, corner-case sequences and
// a randomized run checked against a behavioural model.
module tb_stage_sequencer;
    import stage_pkg::*;

    localparam int     WAIT_MAX = 4;
    localparam int     CNT_W    = 16;
    localparam longint CNT_MAX  = 65535;

    logic             Clock = 1'b0;
    logic             Reset_L = 1'b0;
    logic             Run = 1'b0, Step = 1'b0, Halt_Req = 1'b0;
    logic             Mem_Access = 1'b0, Mem_Ready = 1'b0, Fetch_Ready = 1'b0;
    logic [2:0]       Stage;
    logic             Stage_Adv, Instr_Done, Halted, Timeout_Err;
    logic [CNT_W-1:0] Instr_Count, Stall_Count;
    seq_state_t       dbg_state;

    stage_sequencer #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .Clock       (Clock),
        .Reset_L     (Reset_L),
        .Run         (Run),
        .Step        (Step),
        .Halt_Req    (Halt_Req),
        .Mem_Access  (Mem_Access),
        .Mem_Ready   (Mem_Ready),
        .Fetch_Ready (Fetch_Ready),
        .Stage       (Stage),
        .Stage_Adv   (Stage_Adv),
        .Instr_Done  (Instr_Done),
        .Halted      (Halted),
        .Timeout_Err (Timeout_Err),
        .Instr_Count (Instr_Count),
        .Stall_Count (Stall_Count),
        .dbg_state   (dbg_state)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input bit r, input bit s, input bit h,
                         input bit ma, input bit mr, input bit fr);
        Run = r; Step = s; Halt_Req = h;
        Mem_Access = ma; Mem_Ready = mr; Fetch_Ready = fr;
    endtask

    // Behavioural model: which phase the machine is in, where it is in the
    // five-stage pass, and the bookkeeping the rules ask for.
    bit     m_idle, m_active, m_halted, m_fault;
    bit     m_prime, m_hpend, m_stepmode, m_run_prev, m_done;
    int     m_stage, m_wait;
    longint m_icnt, m_scnt;

    task automatic model_reset();
        m_idle = 1; m_active = 0; m_halted = 0; m_fault = 0;
        m_prime = 0; m_hpend = 0; m_stepmode = 0; m_run_prev = 0; m_done = 0;
        m_stage = 0; m_wait = 0; m_icnt = 0; m_scnt = 0;
    endtask

    task automatic model_step(input bit run, input bit step, input bit hreq,
                              input bit macc, input bit mrdy, input bit frdy,
                              output bit adv);
        bit stall;
        bit rise;
        rise = run && !m_run_prev;
        m_run_prev = run;
        m_done = 0;
        adv = 0;
        if (m_idle) begin
            if (run) begin
                m_idle = 0; m_active = 1; m_stage = 5; m_prime = 1; m_wait = 0;
            end
        end else if (m_halted) begin
            if (rise || step) begin
                m_halted = 0; m_active = 1; m_stage = 1; m_wait = 0;
                m_stepmode = !rise;
            end
        end else if (m_active) begin
            stall = (m_stage == 4 && macc && !mrdy) || (m_stage == 5 && !frdy);
            if (stall) begin
                if (m_scnt < CNT_MAX) m_scnt++;
                if (m_wait == WAIT_MAX) begin
                    m_active = 0; m_fault = 1; m_stage = 0;
                end else begin
                    m_wait++;
                end
            end else begin
                adv = 1;
                m_wait = 0;
                if (m_stage == 2 && hreq) m_hpend = 1;
                if (m_stage == 5 && m_prime) begin
                    m_prime = 0;
                    m_stage = 1;
                end else if (m_stage == 5) begin
                    m_done = 1;
                    if (m_icnt < CNT_MAX) m_icnt++;
                    if (m_hpend || !run || m_stepmode) begin
                        m_active = 0; m_halted = 1; m_stage = 0;
                        m_hpend = 0; m_stepmode = 0;
                    end else begin
                        m_stage = 1;
                    end
                end else begin
                    m_stage = m_stage + 1;
                end
            end
        end
    endtask

    task automatic do_reset();
        Reset_L = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        Reset_L = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [5:0]  ins;   // {Run, Step, Halt_Req, Mem_Access, Mem_Ready, Fetch_Ready}
        logic [2:0]  stage;
        logic        done;
        logic        halted;
        logic [15:0] icnt;
    } vec_t;

    vec_t vecs[20];

    initial begin
        bit adv_exp;
        bit r_run;

        vecs[0]  = '{6'b100011, 3'd5, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{6'b100011, 3'd1, 1'b0, 1'b0, 16'd0};
        vecs[2]  = '{6'b100011, 3'd2, 1'b0, 1'b0, 16'd0};
        vecs[3]  = '{6'b100011, 3'd3, 1'b0, 1'b0, 16'd0};
        vecs[4]  = '{6'b100011, 3'd4, 1'b0, 1'b0, 16'd0};
        vecs[5]  = '{6'b100011, 3'd5, 1'b0, 1'b0, 16'd0};
        vecs[6]  = '{6'b100011, 3'd1, 1'b1, 1'b0, 16'd1};
        vecs[7]  = '{6'b100011, 3'd2, 1'b0, 1'b0, 16'd1};
        vecs[8]  = '{6'b101011, 3'd3, 1'b0, 1'b0, 16'd1};
        vecs[9]  = '{6'b100011, 3'd4, 1'b0, 1'b0, 16'd1};
        vecs[10] = '{6'b100011, 3'd5, 1'b0, 1'b0, 16'd1};
        vecs[11] = '{6'b100011, 3'd0, 1'b1, 1'b1, 16'd2};
        vecs[12] = '{6'b100011, 3'd0, 1'b0, 1'b1, 16'd2};
        vecs[13] = '{6'b110011, 3'd1, 1'b0, 1'b0, 16'd2};
        vecs[14] = '{6'b100011, 3'd2, 1'b0, 1'b0, 16'd2};
        vecs[15] = '{6'b100011, 3'd3, 1'b0, 1'b0, 16'd2};
        vecs[16] = '{6'b100011, 3'd4, 1'b0, 1'b0, 16'd2};
        vecs[17] = '{6'b100011, 3'd5, 1'b0, 1'b0, 16'd2};
        vecs[18] = '{6'b100011, 3'd0, 1'b1, 1'b1, 16'd3};
        vecs[19] = '{6'b100011, 3'd0, 1'b0, 1'b1, 16'd3};

        // Reset state
        #1;
        check("rst_stage", Stage, 0);
        check("rst_adv", Stage_Adv, 0);
        check("rst_done", Instr_Done, 0);
        check("rst_halted", Halted, 0);
        check("rst_timeout", Timeout_Err, 0);
        check("rst_icnt", Instr_Count, 0);
        check("rst_scnt", Stall_Count, 0);
        check("rst_state", dbg_state, SEQ_IDLE);
        tick();
        Reset_L = 1'b1;
        model_reset();

        // Run from reset, Halt_Req in Decode, then a single step
        for (int i = 0; i < 20; i++) begin
            {Run, Step, Halt_Req, Mem_Access, Mem_Ready, Fetch_Ready} = vecs[i].ins;
            tick();
            check($sformatf("vec%0d_stage", i), Stage, vecs[i].stage);
            check($sformatf("vec%0d_done", i), Instr_Done, vecs[i].done);
            check($sformatf("vec%0d_halted", i), Halted, vecs[i].halted);
            check($sformatf("vec%0d_icnt", i), Instr_Count, vecs[i].icnt);
        end

        // Memory wait states within budget
        do_reset();
        drive(1, 0, 0, 1, 1, 1);
        repeat (5) tick();
        check("mem_at4", Stage, 4);
        Mem_Ready = 1'b0;
        #1;
        check("mem_adv_stall", Stage_Adv, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("mem_hold%0d", i), Stage, 4);
            check($sformatf("mem_nofault%0d", i), Timeout_Err, 0);
        end
        Mem_Ready = 1'b1;
        tick();
        check("mem_release", Stage, 5);
        check("mem_scnt", Stall_Count, 3);
        check("mem_timeout", Timeout_Err, 0);

        // Fetch wait-state timeout
        do_reset();
        drive(1, 0, 0, 0, 1, 1);
        repeat (6) tick();
        check("ftch_at5", Stage, 5);
        Fetch_Ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("ftch_hold%0d", i), Stage, 5);
            check($sformatf("ftch_nofault%0d", i), Timeout_Err, 0);
        end
        check("ftch_scnt4", Stall_Count, 4);
        tick();
        check("ftch_fault_stage", Stage, 0);
        check("ftch_fault_flag", Timeout_Err, 1);
        check("ftch_fault_state", dbg_state, SEQ_FAULT);
        Fetch_Ready = 1'b1;
        repeat (3) tick();
        check("ftch_sticky_stage", Stage, 0);
        check("ftch_sticky_flag", Timeout_Err, 1);
        do_reset();
        check("ftch_cleared", Timeout_Err, 0);

        // Asynchronous reset in Execute, Run held through release
        drive(1, 0, 0, 0, 1, 1);
        repeat (9) tick();
        check("arst_at3", Stage, 3);
        check("arst_icnt_before", Instr_Count, 1);
        #2;
        Reset_L = 1'b0;
        #1;
        check("arst_stage", Stage, 0);
        check("arst_icnt", Instr_Count, 0);
        Reset_L = 1'b1;
        tick();
        check("arst_reprime", Stage, 5);

        // Retirement counter saturation
        do_reset();
        drive(1, 0, 0, 0, 1, 1);
        repeat (2) tick();
        force dut.u_instr_cnt.count = 16'hFFFE;
        #1;
        release dut.u_instr_cnt.count;
        repeat (5) tick();
        check("sat_reach", Instr_Count, 16'hFFFF);
        repeat (5) tick();
        check("sat_done", Instr_Done, 1);
        check("sat_hold", Instr_Count, 16'hFFFF);

        // Randomized run against the model
        do_reset();
        r_run = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                Reset_L = 1'b0;
                #1;
                check("rnd_arst_stage", Stage, 0);
                check("rnd_arst_icnt", Instr_Count, 0);
                Reset_L = 1'b1;
                model_reset();
            end
            if ($urandom_range(0, 99) < 3) r_run = !r_run;
            drive(r_run, $urandom_range(0, 19) == 0, $urandom_range(0, 6) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) != 0);
            #1;
            model_step(Run, Step, Halt_Req, Mem_Access, Mem_Ready, Fetch_Ready, adv_exp);
            check("rnd_adv", Stage_Adv, adv_exp);
            tick();
            check("rnd_stage", Stage, m_stage);
            check("rnd_done", Instr_Done, m_done);
            check("rnd_halted", Halted, m_halted);
            check("rnd_timeout", Timeout_Err, m_fault);
            check("rnd_icnt", Instr_Count, m_icnt);
            if (!m_fault) check("rnd_scnt", Stall_Count, m_scnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
